// File: rtl/psum_pkg.sv
// Shared sizes, FSM state type and saturation limits for the psum scratchpad
// controller and the reusable psum adder.
package psum_pkg;

   localparam int PSUM_DEPTH = 24;
   localparam int PSUM_DW    = 16;
   localparam int PSUM_AW    = 5;

   localparam logic [PSUM_DW-1:0] PSUM_SAT_MAX = {1'b0, {(PSUM_DW-1){1'b1}}};
   localparam logic [PSUM_DW-1:0] PSUM_SAT_MIN = {1'b1, {(PSUM_DW-1){1'b0}}};

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_CAP,
      ST_WR,
      ST_DRD,
      ST_DCAP,
      ST_DOUT
   } psum_state_e;

endpackage

// File: rtl/psum_adder.sv
// Combinational signed psum add; defining PSUM_SAT_EN clamps on signed overflow
// instead of wrapping modulo 2^PSUM_DW.
module psum_adder
   import psum_pkg::*;
(
   input  logic [PSUM_DW-1:0] a,
   input  logic [PSUM_DW-1:0] b,
   output logic [PSUM_DW-1:0] sum
);

`ifdef PSUM_SAT_EN
   logic [PSUM_DW:0] wide;

   // Overflow shows up as the extra sign bit disagreeing with the result sign.
   always_comb begin
      wide = {a[PSUM_DW-1], a} + {b[PSUM_DW-1], b};
      if (wide[PSUM_DW] != wide[PSUM_DW-1]) begin
         sum = wide[PSUM_DW] ? PSUM_SAT_MIN : PSUM_SAT_MAX;
      end else begin
         sum = wide[PSUM_DW-1:0];
      end
   end
`else
   always_comb begin
      sum = a + b;
   end
`endif

endmodule

// File: rtl/psum_spad_ctrl.sv
// Bus initiator for the psum scratchpad: read-modify-write accumulates and a full
// in-order drain stream. Define PSUM_SAT_EN for saturating accumulation.
module psum_spad_ctrl
   import psum_pkg::*;
#(
   parameter int DEPTH = PSUM_DEPTH,
   parameter int DW    = PSUM_DW,
   parameter int AW    = PSUM_AW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          acc_valid,
   output logic          acc_ready,
   input  logic [AW-1:0] acc_addr,
   input  logic [DW-1:0] acc_data,
   input  logic          acc_first,
   input  logic          drain_start,
   output logic          drain_busy,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [AW-1:0] out_addr,
   output logic          addr_err,
   output logic [AW-1:0] spad_addr,
   output logic          spad_we,
   inout  wire  [DW-1:0] spad_data
);

   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   psum_state_e   state_q, state_d;
   logic [AW-1:0] spad_addr_q, spad_addr_d;
   logic [AW-1:0] out_addr_q, out_addr_d;
   logic [DW-1:0] addend_q, addend_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] out_data_q, out_data_d;
   logic [DW-1:0] sum;
   logic          we_q, we_d;
   logic          addr_err_q, addr_err_d;
   logic          idle, drain_fire, acc_fire, acc_in_range, drain_last, out_fire;

   assign idle         = (state_q == ST_IDLE);
   assign drain_fire   = idle && drain_start;
   assign acc_fire     = idle && acc_valid && !drain_start;
   assign acc_in_range = (acc_addr <= LAST_IDX);
   assign drain_last   = (spad_addr_q == LAST_IDX);
   assign out_fire     = (state_q == ST_DOUT) && out_ready;

   psum_adder u_adder (
      .a   (spad_data),
      .b   (addend_q),
      .sum (sum)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (drain_start) begin
               state_d = ST_DRD;
            end else if (acc_valid && acc_in_range) begin
               state_d = acc_first ? ST_WR : ST_RD;
            end
         end
         ST_RD:   state_d = ST_CAP;
         ST_CAP:  state_d = ST_WR;
         ST_WR:   state_d = ST_IDLE;
         ST_DRD:  state_d = ST_DCAP;
         ST_DCAP: state_d = ST_DOUT;
         ST_DOUT: begin
            if (out_ready) begin
               state_d = drain_last ? ST_IDLE : ST_DRD;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      acc_ready  = 1'b0;
      out_valid  = 1'b0;
      drain_busy = 1'b0;
      unique case (state_q)
         ST_IDLE:          acc_ready  = rst_n && !drain_start;
         ST_DRD, ST_DCAP:  drain_busy = 1'b1;
         ST_DOUT: begin
            drain_busy = 1'b1;
            out_valid  = 1'b1;
         end
         default: ;
      endcase
   end

   // During a drain spad_addr_q doubles as the walk index.
   always_comb begin
      spad_addr_d = spad_addr_q;
      addend_d    = addend_q;
      wdata_d     = wdata_q;
      out_data_d  = out_data_q;
      out_addr_d  = out_addr_q;
      addr_err_d  = addr_err_q;
      if (drain_fire) begin
         spad_addr_d = '0;
      end else if (acc_fire) begin
         if (acc_in_range) begin
            spad_addr_d = acc_addr;
            addend_d    = acc_data;
            wdata_d     = acc_data;
         end else begin
            addr_err_d  = 1'b1;
         end
      end
      if (state_q == ST_CAP) begin
         wdata_d = sum;
      end
      if (state_q == ST_DCAP) begin
         out_data_d = spad_data;
         out_addr_d = spad_addr_q;
      end
      if (out_fire && !drain_last) begin
         spad_addr_d = spad_addr_q + AW'(1);
      end
   end

   assign we_d = (state_d == ST_WR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spad_addr_q <= '0;
         addend_q    <= '0;
         wdata_q     <= '0;
         out_data_q  <= '0;
         out_addr_q  <= '0;
         addr_err_q  <= 1'b0;
         we_q        <= 1'b0;
      end else begin
         spad_addr_q <= spad_addr_d;
         addend_q    <= addend_d;
         wdata_q     <= wdata_d;
         out_data_q  <= out_data_d;
         out_addr_q  <= out_addr_d;
         addr_err_q  <= addr_err_d;
         we_q        <= we_d;
      end
   end

   // One flop gates both the write strobe and the bus driver, so they never disagree.
   assign spad_data = we_q ? wdata_q : {DW{1'bz}};
   assign spad_we   = we_q;
   assign spad_addr = spad_addr_q;
   assign out_data  = out_data_q;
   assign out_addr  = out_addr_q;
   assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_psum_spad_ctrl.sv
// Scoreboard bench for psum_spad_ctrl with a behavioural scratchpad and an
// array-based reference of the psum contents (honours PSUM_SAT_EN).
module tb_psum_spad_ctrl;

   localparam int DEPTH = 24;
   localparam int DW    = 16;
   localparam int AW    = 5;

   localparam int K_OVR       = 0;
   localparam int K_ACC       = 1;
   localparam int K_DRAIN     = 2;
   localparam int K_DRAIN_ACC = 3;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          acc_valid = 1'b0;
   logic          acc_ready;
   logic [AW-1:0] acc_addr = '0;
   logic [DW-1:0] acc_data = '0;
   logic          acc_first = 1'b0;
   logic          drain_start = 1'b0;
   logic          drain_busy;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [DW-1:0] out_data;
   logic [AW-1:0] out_addr;
   logic          addr_err;
   logic [AW-1:0] spad_addr;
   logic          spad_we;
   wire  [DW-1:0] spad_data;

   logic [DW-1:0] spad_mem [32];
   logic [DW-1:0] spad_rd_q = '0;
   logic [DW-1:0] ref_mem [DEPTH];
   logic          ref_err = 1'b0;
   exp_t          exp_q [$];
   exp_t          mon_e;
   int            errors = 0;
   int            checks = 0;
   int            we_cnt = 0;
   int            ready_mode = 0;
   bit            last_seen = 1'b0;

   psum_spad_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .acc_valid   (acc_valid),
      .acc_ready   (acc_ready),
      .acc_addr    (acc_addr),
      .acc_data    (acc_data),
      .acc_first   (acc_first),
      .drain_start (drain_start),
      .drain_busy  (drain_busy),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_addr    (out_addr),
      .addr_err    (addr_err),
      .spad_addr   (spad_addr),
      .spad_we     (spad_we),
      .spad_data   (spad_data)
   );

   always #5 clk = ~clk;

   // Scratchpad: registered read, write on spad_we, drives the bus only when not written.
   always @(posedge clk) begin
      if (spad_we === 1'b1) spad_mem[spad_addr] <= spad_data;
      else spad_rd_q <= spad_mem[spad_addr];
   end
   assign spad_data = (rst_n && spad_we !== 1'b1) ? spad_rd_q : {DW{1'bz}};

   always @(negedge clk) begin
      if (spad_we === 1'b1) we_cnt++;
   end

   always begin
      @(posedge clk);
      #2;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ~out_ready;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   function automatic logic [DW-1:0] ref_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
      int s;
      s = int'($signed(a)) + int'($signed(b));
`ifdef PSUM_SAT_EN
      if (s > 32767) return 16'h7FFF;
      if (s < -32768) return 16'h8000;
`endif
      return DW'(s);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic model_acc(input bit first, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      if (int'(addr) < DEPTH) begin
         if (first) ref_mem[addr] = data;
         else ref_mem[addr] = ref_add(ref_mem[addr], data);
      end else begin
         ref_err = 1'b1;
      end
   endtask

   task automatic wait_idle(input string name);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!acc_ready && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 500) checkOutput(name, 0, 1);
   endtask

   task automatic applyStimulus(input int kind, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      int guard;
      int bad;
      if (kind == K_OVR || kind == K_ACC) begin
         wait_idle("acc_wait_timeout");
         acc_valid = 1'b1;
         acc_first = (kind == K_OVR);
         acc_addr  = addr;
         acc_data  = data;
         @(posedge clk);
         #1;
         acc_valid = 1'b0;
         acc_addr  = AW'($urandom);
         acc_data  = DW'($urandom);
         acc_first = 1'($urandom_range(0, 1));
         model_acc(kind == K_OVR, addr, data);
      end else begin
         wait_idle("drain_wait_timeout");
         drain_start = 1'b1;
         if (kind == K_DRAIN_ACC) begin
            acc_valid = 1'b1;
            acc_first = 1'b0;
            acc_addr  = addr;
            acc_data  = data;
         end
         for (int i = 0; i < DEPTH; i++) exp_q.push_back('{addr: AW'(i), data: ref_mem[i]});
         bad = 0;
         @(posedge clk);
         #1;
         drain_start = 1'b0;
         @(negedge clk);
         checkOutput("valid_latency_c1", out_valid, 0);
         checkOutput("drain_busy_rise", drain_busy, 1);
         if (acc_ready) bad++;
         @(negedge clk);
         checkOutput("valid_latency_c2", out_valid, 0);
         if (acc_ready) bad++;
         @(negedge clk);
         checkOutput("valid_latency_c3", out_valid, 1);
         guard = 0;
         while (drain_busy && guard < 3000) begin
            if (acc_ready) bad++;
            @(negedge clk);
            guard++;
         end
         checkOutput("drain_completes", 32'(guard < 3000), 1);
         checkOutput("drain_all_words", exp_q.size(), 0);
         if (kind == K_DRAIN_ACC) begin
            checkOutput("acc_ready_low_during_drain", bad, 0);
            checkOutput("acc_ready_after_drain", acc_ready, 1);
            @(posedge clk);
            #1;
            acc_valid = 1'b0;
            model_acc(1'b0, addr, data);
         end
      end
   endtask

   // Monitor: pops the scoreboard on every drain handshake.
   always @(negedge clk) begin
      if (rst_n) begin
         if (last_seen) begin
            last_seen = 1'b0;
            checkOutput("drain_busy_after_last", drain_busy, 0);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_drain_word", 1, 0);
            end else begin
               mon_e = exp_q.pop_front();
               checkOutput("drain_addr", out_addr, mon_e.addr);
               checkOutput("drain_data", out_data, mon_e.data);
               checkOutput("drain_busy_during_word", drain_busy, 1);
               if (int'(mon_e.addr) == DEPTH - 1) last_seen = 1'b1;
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int base;
      for (int i = 0; i < 32; i++) spad_mem[i] = '0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

      #1 rst_n = 1'b0;
      #3;
      checkOutput("rst_spad_we", spad_we, 0);
      checkOutput("rst_spad_addr", spad_addr, 0);
      checkOutput("rst_bus_released", 32'(spad_data === {DW{1'bz}}), 1);
      checkOutput("rst_acc_ready", acc_ready, 0);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_out_data", out_data, 0);
      checkOutput("rst_out_addr", out_addr, 0);
      checkOutput("rst_drain_busy", drain_busy, 0);
      checkOutput("rst_addr_err", addr_err, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("idle_acc_ready", acc_ready, 1);

      $display("[TB] overwrite then accumulate at addr 3");
      base = we_cnt;
      applyStimulus(K_OVR, 5'd3, 16'h0010);
      applyStimulus(K_ACC, 5'd3, 16'h0005);
      wait_idle("t1_idle_timeout");
      checkOutput("t1_we_cycles", we_cnt - base, 2);
      checkOutput("t1_model_entry3", ref_mem[3], 16'h0015);

      $display("[TB] overflow at addr 7");
      applyStimulus(K_OVR, 5'd7, 16'h7FF0);
      applyStimulus(K_ACC, 5'd7, 16'h0020);
      ready_mode = 0;
      applyStimulus(K_DRAIN, '0, '0);

      $display("[TB] random accumulate traffic");
      ready_mode = 2;
      for (int n = 0; n < 40; n++) begin
         applyStimulus($urandom_range(K_OVR, K_ACC), AW'($urandom_range(0, DEPTH - 1)), DW'($urandom));
      end
      applyStimulus(K_DRAIN, '0, '0);

      $display("[TB] ordered drain with toggling out_ready");
      for (int i = 0; i < DEPTH; i++) applyStimulus(K_OVR, AW'(i), DW'(i));
      ready_mode = 1;
      applyStimulus(K_DRAIN, '0, '0);

      $display("[TB] drain_start and acc_valid together");
      ready_mode = 2;
      applyStimulus(K_DRAIN_ACC, 5'd5, 16'h0100);
      ready_mode = 0;
      applyStimulus(K_DRAIN, '0, '0);

      $display("[TB] out-of-range address");
      checkOutput("addr_err_before", addr_err, 0);
      base = we_cnt;
      applyStimulus(K_ACC, 5'd25, 16'h1234);
      repeat (4) @(negedge clk);
      checkOutput("addr_err_set", addr_err, ref_err);
      checkOutput("addr_err_no_write", we_cnt - base, 0);
      applyStimulus(K_OVR, 5'd2, 16'h0042);
      wait_idle("t5_idle_timeout");
      checkOutput("addr_err_sticky", addr_err, 1);

      $display("[TB] reset during WR");
      wait_idle("t6_idle_timeout");
      acc_valid = 1'b1;
      acc_first = 1'b1;
      acc_addr  = 5'd9;
      acc_data  = 16'hBEEF;
      @(posedge clk);
      #1;
      acc_valid = 1'b0;
      checkOutput("wr_spad_we", spad_we, 1);
      checkOutput("wr_spad_addr", spad_addr, 9);
      checkOutput("wr_bus_data", spad_data, 16'hBEEF);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("arst_spad_we", spad_we, 0);
      checkOutput("arst_bus_released", 32'(spad_data === {DW{1'bz}}), 1);
      checkOutput("arst_spad_addr", spad_addr, 0);
      checkOutput("arst_acc_ready", acc_ready, 0);
      checkOutput("arst_addr_err", addr_err, 0);
      checkOutput("arst_out_valid", out_valid, 0);
      checkOutput("arst_drain_busy", drain_busy, 0);
      ref_err = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      ready_mode = 2;
      applyStimulus(K_DRAIN, '0, '0);
      checkOutput("final_addr_err", addr_err, ref_err);

      checkOutput("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/psum_spad_ctrl.md
# psum_spad_ctrl

Initiator for the 24×16-bit partial-sum scratchpad's shared bus. It accepts accumulate requests from the PE datapath and performs read-modify-write cycles on the scratchpad through its `addr`/`we`/bidirectional `data_port` interface. It also drains all entries in address order onto a valid/ready output stream. It sits between the PE MAC pipeline and the psum scratchpad, and owns bus direction so that drivers never contend.

## Interface
- `DEPTH`, 24: number of scratchpad entries; drain walks addresses 0..DEPTH-1.
- `DW`, 16: psum data width, two's complement.
- `AW`, 5: scratchpad address width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `acc_valid` in 1: accumulate request valid.
- `acc_ready` out 1: request accepted when `acc_valid && acc_ready` at a rising edge.
- `acc_addr` in AW: target entry.
- `acc_data` in DW: signed addend.
- `acc_first` in 1: overwrite the entry with `acc_data` instead of accumulating.
- `drain_start` in 1: one-cycle pulse that starts a full readout.
- `drain_busy` out 1: high from drain acceptance until the last word handshakes.
- `out_valid` out 1, `out_ready` in 1, `out_data` out DW, `out_addr` out AW: drain stream.
- `addr_err` out 1: sticky flag, set by an accepted request with `acc_addr >= DEPTH`.
- `spad_addr` out AW, `spad_we` out 1, `spad_data` inout DW: scratchpad bus.

## Operation
- FSM states: IDLE, RD, CAP, WR, DRD, DCAP, DOUT.
- In IDLE, `acc_ready=1` unless `drain_start` is high. When `drain_start` and `acc_valid` are both high, the drain wins.
- Accepted request with `acc_first=0`: IDLE→RD→CAP→WR→IDLE.
  - RD: `spad_addr=acc_addr`, `spad_we=0`. The scratchpad registers the entry at the edge that ends RD.
  - CAP: `spad_we=0`. Sample `spad_data` and register `sum = sample + addend`.
  - WR: `spad_we=1`, drive `sum` on `spad_data`.
- Accepted request with `acc_first=1`: IDLE→WR→IDLE, driving `acc_data` directly.
- `acc_addr`, `acc_data` and `acc_first` are captured at acceptance. Inputs may change afterwards.
- Out-of-range address: the request is accepted and dropped (no bus write), `addr_err` is set, and the FSM stays in IDLE.
- Drain: for each index i from 0 to DEPTH-1, run DRD (read i) → DCAP (sample into `out_data`, `out_addr=i`) → DOUT.
  - DOUT holds `out_valid=1` with stable data until `out_ready`.
  - On that handshake, go to DRD for i+1. After i=DEPTH-1, go to IDLE and clear `drain_busy`.
- `spad_data` is driven only while the registered `spad_we=1`; otherwise it is high-Z. Drive enable and `spad_we` come from the same flop.
- Arithmetic: full-width signed addition, wrapping modulo 2^DW unless `PSUM_SAT_EN` is defined.

## Timing
- Reset values: `spad_we=0`, `spad_addr=0`, bus released, `acc_ready=0` while `rst_n` is low (1 in IDLE afterwards), `out_valid=0`, `out_data=0`, `out_addr=0`, `drain_busy=0`, `addr_err=0`, FSM in IDLE.
- Accumulate occupies the bus for 3 cycles. The write lands at the edge ending WR, and the next request is accepted in the following IDLE cycle, so throughput is one accumulate per 4 cycles.
- Overwrite takes 2 cycles: WR, then IDLE.
- Back-to-back requests to the same address see the previous write, because RD always follows a completed WR edge.
- Drain latency: `out_valid` rises 3 cycles after `drain_start`. The minimum drain time is 3×DEPTH cycles.
- Reset mid-operation aborts immediately. `spad_we` goes low asynchronously, the bus is released, and a write in progress is lost.

## Configuration
- `PSUM_SAT_EN` defined: the accumulate clamps to 0x7FFF / 0x8000 on signed overflow.
- `PSUM_SAT_EN` undefined: two's-complement wrap.
- Overwrite and drain paths are unaffected either way.

## Structure
- Shared package `psum_pkg`:
  - `PSUM_DEPTH=24`, `PSUM_DW=16`, `PSUM_AW=5`.
  - FSM state enum typedef.
  - Saturation limit constants.
- Sub-module `psum_adder`: combinational signed add, with saturation selected under `PSUM_SAT_EN`. Reusable by the PE.

## Test plan
- Reset, then overwrite addr 3 with 0x0010, then accumulate 0x0005 at addr 3. Drain reports entry 3 = 0x0015, and the bus shows `spad_we` high exactly 2 cycles total.
- Overwrite addr 7 with 0x7FF0, accumulate 0x0020. Entry 7 = 0x7FFF with `PSUM_SAT_EN`, 0x8010 without.
- Overwrite every address i with i, drain while toggling `out_ready` every other cycle. The stream must be 0..23 in order with no drops or duplicates, and `drain_busy` must fall after word 23.
- Assert `drain_start` and `acc_valid` in the same cycle. The drain runs first and `acc_ready` stays low until `drain_busy` falls.
- Request with `acc_addr=25`. `addr_err` goes high and stays high, and no `spad_we` pulse occurs.
- Assert `rst_n` low during WR. `spad_we` drops and `spad_data` is high-Z without waiting for a clock edge, and all outputs are at their reset values.
